// File: rtl/mgr_array_oob_arbiter.sv
// Packet-level round-robin arbiter that merges the per-manager OOB request
// ports onto the single downstream OOB stack channel. A grant is held from
// the first beat of a packet until its last beat (SOM or EOP). Beats leave
// through one registered output stage with valid/ready flow control.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no manager granted; pick the next requester round-robin
//   LOCK  | grant held; forward beats of the granted manager until last
module mgr_array_oob_arbiter #(
    parameter int NUM_MGR  = 4,
    parameter int MGR_ID_W = 2,
    parameter int TYPE_W   = 2,
    parameter int DATA_W   = 64
) (
    input  logic                       clk,
    input  logic                       reset_poweron,
    input  logic [NUM_MGR-1:0]         mgr__arb__oob_valid,
    input  logic [2*NUM_MGR-1:0]       mgr__arb__oob_cntl,
    input  logic [TYPE_W*NUM_MGR-1:0]  mgr__arb__oob_type,
    input  logic [DATA_W*NUM_MGR-1:0]  mgr__arb__oob_data,
    output logic [NUM_MGR-1:0]         arb__mgr__oob_ready,
    output logic                       arb__std__oob_valid,
    output logic [1:0]                 arb__std__oob_cntl,
    output logic [TYPE_W-1:0]          arb__std__oob_type,
    output logic [DATA_W-1:0]          arb__std__oob_data,
    input  logic                       std__arb__oob_ready,
    output logic [MGR_ID_W-1:0]        arb__sys__grant_id,
    output logic                       arb__sys__busy
);

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [MGR_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [MGR_ID_W-1:0] grant_q, grant_d;
    logic                out_valid_q, out_valid_d;
    logic [1:0]          out_cntl_q, out_cntl_d;
    logic [TYPE_W-1:0]   out_type_q, out_type_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic                any_req;
    logic [MGR_ID_W-1:0] winner;
    logic [MGR_ID_W-1:0] cand;
    int                  gidx;
    logic                sel_valid;
    logic [1:0]          sel_cntl;
    logic [TYPE_W-1:0]   sel_type;
    logic [DATA_W-1:0]   sel_data;
    logic                ld;
    logic                accept;
    logic                sel_last;

    // Beat fields of the currently granted manager
    always_comb begin
        gidx      = int'(grant_q);
        sel_valid = mgr__arb__oob_valid[grant_q];
        sel_cntl  = mgr__arb__oob_cntl[2*gidx +: 2];
        sel_type  = mgr__arb__oob_type[TYPE_W*gidx +: TYPE_W];
        sel_data  = mgr__arb__oob_data[DATA_W*gidx +: DATA_W];
    end

    // Round-robin winner: first requester at or above rr_ptr, with wrap.
    // Scanning from the far end down lets the closest requester win last.
    always_comb begin
        any_req = |mgr__arb__oob_valid;
        winner  = rr_ptr_q;
        cand    = '0;
        for (int k = NUM_MGR - 1; k >= 0; k--) begin
            cand = rr_ptr_q + MGR_ID_W'(k);
            if (mgr__arb__oob_valid[cand]) begin
                winner = cand;
            end
        end
    end

    // Handshake terms; SOM (11) and EOP (10) are exactly the codes with bit 1 set
    always_comb begin
        ld       = !out_valid_q || std__arb__oob_ready;
        accept   = (state_q == ST_LOCK) && sel_valid && ld;
        sel_last = sel_cntl[1];
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req) state_d = ST_LOCK;
            ST_LOCK: if (accept && sel_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: only the granted manager sees ready, and only while the stage can load
    always_comb begin
        arb__mgr__oob_ready = '0;
        if (state_q == ST_LOCK) begin
            arb__mgr__oob_ready[grant_q] = ld;
        end
        arb__sys__busy = (state_q == ST_LOCK) || out_valid_q;
    end

    // Grant, pointer and output-stage next values
    always_comb begin
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_cntl_d  = out_cntl_q;
        out_type_d  = out_type_q;
        out_data_d  = out_data_q;
        if (state_q == ST_IDLE && any_req) begin
            grant_d = winner;
        end
        if (accept && sel_last) begin
            rr_ptr_d = grant_q + 1'b1;
        end
        if (accept) begin
            out_valid_d = 1'b1;
            out_cntl_d  = sel_cntl;
            out_type_d  = sel_type;
            out_data_d  = sel_data;
        end else if (std__arb__oob_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_cntl_q  <= '0;
            out_type_q  <= '0;
            out_data_q  <= '0;
        end else begin
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_cntl_q  <= out_cntl_d;
            out_type_q  <= out_type_d;
            out_data_q  <= out_data_d;
        end
    end

    assign arb__std__oob_valid = out_valid_q;
    assign arb__std__oob_cntl  = out_cntl_q;
    assign arb__std__oob_type  = out_type_q;
    assign arb__std__oob_data  = out_data_q;
    assign arb__sys__grant_id  = grant_q;

endmodule

// File: tb/tb_mgr_array_oob_arbiter.sv
// Bench for mgr_array_oob_arbiter: packet-level round-robin reference model
// feeding a scoreboard, randomized packets, gaps and stack backpressure.
module tb_mgr_array_oob_arbiter;

    localparam int NM = 4;

    typedef struct packed {
        logic [1:0]  cntl;
        logic [1:0]  typ;
        logic [63:0] data;
        logic        first;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   mgr_valid = '0;
    logic [7:0]   mgr_cntl = '0;
    logic [7:0]   mgr_type = '0;
    logic [255:0] mgr_data = '0;
    logic [3:0]   ready_o;
    logic         out_v;
    logic [1:0]   out_cntl;
    logic [1:0]   out_type;
    logic [63:0]  out_data;
    logic         std_ready = 1'b1;
    logic [1:0]   grant_id;
    logic         busy;

    mgr_array_oob_arbiter #(.NUM_MGR(4), .MGR_ID_W(2), .TYPE_W(2), .DATA_W(64)) dut (
        .clk                 (clk),
        .reset_poweron       (rst),
        .mgr__arb__oob_valid (mgr_valid),
        .mgr__arb__oob_cntl  (mgr_cntl),
        .mgr__arb__oob_type  (mgr_type),
        .mgr__arb__oob_data  (mgr_data),
        .arb__mgr__oob_ready (ready_o),
        .arb__std__oob_valid (out_v),
        .arb__std__oob_cntl  (out_cntl),
        .arb__std__oob_type  (out_type),
        .arb__std__oob_data  (out_data),
        .std__arb__oob_ready (std_ready),
        .arb__sys__grant_id  (grant_id),
        .arb__sys__busy      (busy)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    beat_t mq[NM][$];
    int    plen[NM][$];
    beat_t exp_out[$];
    int    exp_mgr[$];
    int    out_cyc[$];
    int    m_ptr = 0;
    int    pops = 0;
    bit    mon_en = 1'b0;
    logic  prev_v = 1'b0;
    logic  prev_r = 1'b0;
    logic [67:0] prev_beat = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Append one packet for manager m; data runs base, base+1, ...
    task automatic add_pkt(input int m, input int len, input bit mom_start, input logic [63:0] base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.typ   = 2'($urandom_range(3));
            b.data  = base + 64'(i);
            b.first = (i == 0);
            if (len == 1)          b.cntl = 2'b11;
            else if (i == len - 1) b.cntl = 2'b10;
            else if (i == 0)       b.cntl = mom_start ? 2'b00 : 2'b01;
            else                   b.cntl = 2'b00;
            mq[m].push_back(b);
        end
        plen[m].push_back(len);
    endtask

    // Reference: whole packets granted round-robin among managers with packets left
    function automatic void compute_expected();
        int pk[NM];
        int bi[NM];
        int g;
        for (int m = 0; m < NM; m++) begin
            pk[m] = 0;
            bi[m] = 0;
        end
        while (1) begin
            g = -1;
            for (int k = 0; k < NM; k++) begin
                if (g < 0 && pk[(m_ptr + k) % NM] < plen[(m_ptr + k) % NM].size())
                    g = (m_ptr + k) % NM;
            end
            if (g < 0) break;
            for (int j = 0; j < plen[g][pk[g]]; j++) begin
                exp_out.push_back(mq[g][bi[g] + j]);
                exp_mgr.push_back(g);
            end
            bi[g] += plen[g][pk[g]];
            pk[g]++;
            m_ptr = (g + 1) % NM;
        end
        for (int m = 0; m < NM; m++) plen[m].delete();
    endfunction

    // Monitor: compares accepted input beats and delivered output beats with the scoreboard
    always @(negedge clk) begin
        int e;
        beat_t b;
        if (mon_en && !rst) begin
            if (prev_v && !prev_r)
                chk("hold", {out_v, out_cntl, out_type, out_data}, {1'b1, prev_beat});
            checks++;
            if ($countones(ready_o) > 1 || (ready_o != 0 && out_v && !std_ready)) begin
                failures++;
                $display("FAIL ready_legal actual=%b required=onehot_when_loadable", ready_o);
            end
            for (int m = 0; m < NM; m++) begin
                if (mgr_valid[m] && ready_o[m]) begin
                    if (exp_mgr.size() == 0) begin
                        chk("unexpected_accept", 68'(m), 68'hF);
                    end else begin
                        e = exp_mgr.pop_front();
                        chk("grant_order", 68'(m), 68'(e));
                        chk("grant_id", 68'(grant_id), 68'(m));
                    end
                end
            end
            if (out_v && std_ready) begin
                if (exp_out.size() == 0) begin
                    chk("unexpected_out", {out_cntl, out_type, out_data}, '1);
                end else begin
                    b = exp_out.pop_front();
                    chk("out_beat", {out_cntl, out_type, out_data}, {b.cntl, b.typ, b.data});
                    out_cyc.push_back(cyc);
                    pops++;
                end
            end
            prev_v    = out_v;
            prev_r    = std_ready;
            prev_beat = {out_cntl, out_type, out_data};
        end
    end

    // Drive all queued packets; gaps only on non-first beats, so arbitration stays predictable
    task automatic run_phase(input int gap_pct, input int bp_pct, input int stall_trig, input bit check_rate);
        bit    acc[NM];
        int    budget = 3000;
        int    stall_left = 0;
        bit    stalled = 0;
        bit    done;
        beat_t b;
        compute_expected();
        out_cyc.delete();
        pops = 0;
        for (int m = 0; m < NM; m++) acc[m] = 0;
        while (1) begin
            @(posedge clk);
            for (int m = 0; m < NM; m++) if (acc[m]) void'(mq[m].pop_front());
            #1;
            for (int m = 0; m < NM; m++) begin
                if (mq[m].size() > 0) begin
                    b = mq[m][0];
                    mgr_cntl[2*m +: 2]  = b.cntl;
                    mgr_type[2*m +: 2]  = b.typ;
                    mgr_data[64*m +: 64] = b.data;
                    mgr_valid[m] = b.first ? 1'b1 : ($urandom_range(99) >= gap_pct);
                end else begin
                    mgr_valid[m] = 1'b0;
                end
            end
            if (stall_left > 0) begin
                std_ready = 1'b0;
                stall_left--;
            end else if (stall_trig >= 0 && !stalled && pops == stall_trig) begin
                stalled = 1;
                stall_left = 4;
                std_ready = 1'b0;
            end else begin
                std_ready = ($urandom_range(99) >= bp_pct);
            end
            @(negedge clk);
            for (int m = 0; m < NM; m++) acc[m] = mgr_valid[m] && ready_o[m];
            done = (exp_out.size() == 0) && (exp_mgr.size() == 0);
            for (int m = 0; m < NM; m++) if (mq[m].size() > 0) done = 0;
            if (done) break;
            budget--;
            if (budget == 0) begin
                chk("phase_timeout", 68'(exp_out.size()), 68'd0);
                for (int m = 0; m < NM; m++) mq[m].delete();
                exp_out.delete();
                exp_mgr.delete();
                break;
            end
        end
        mgr_valid = '0;
        std_ready = 1'b1;
        if (check_rate)
            for (int i = 1; i < out_cyc.size(); i++)
                chk("som_rate", 68'(out_cyc[i] - out_cyc[i-1]), 68'd2);
    endtask

    initial begin
        int n;
        // Reset values, during and after reset
        repeat (3) @(negedge clk);
        chk("rst_outputs", {ready_o, out_v, out_cntl, out_type, out_data, grant_id, busy}, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_outputs", {ready_o, out_v, out_cntl, out_type, out_data, grant_id, busy}, '0);
        mon_en = 1'b1;

        // Single SOM from manager 2: ready at t+1, output at t+2
        add_pkt(2, 1, 0, 64'hA5);
        mq[2][0].typ = 2'd1;
        compute_expected();
        mq[2].delete();
        @(posedge clk); #1;
        mgr_valid[2] = 1'b1; mgr_cntl[5:4] = 2'b11; mgr_type[5:4] = 2'd1; mgr_data[191:128] = 64'hA5;
        @(negedge clk);
        chk("lat_t_ready", 68'(ready_o), 68'h0);
        @(negedge clk);
        chk("lat_t1_ready", 68'(ready_o), 68'h4);
        chk("lat_t1_outv", 68'(out_v), 68'h0);
        @(posedge clk); #1;
        mgr_valid = '0;
        @(negedge clk);
        chk("lat_t2_out", {out_v, out_cntl, out_data}, {1'b1, 2'b11, 64'hA5});
        chk("lat_grant_id", 68'(grant_id), 68'd2);
        repeat (2) @(negedge clk);

        // All four managers stream SOM packets: one beat every two cycles
        for (int m = 0; m < NM; m++) begin
            add_pkt(m, 1, 0, 64'(16 * m + 1));
            add_pkt(m, 1, 0, 64'(16 * m + 2));
        end
        run_phase(0, 0, -1, 1);

        // Steer the pointer to 1, then a 4-beat packet on mgr 1 against mgr 0, with a 5-cycle stall
        add_pkt(0, 1, 0, 64'h55);
        run_phase(0, 0, -1, 0);
        add_pkt(1, 4, 0, 64'd1);
        add_pkt(0, 1, 0, 64'h77);
        run_phase(0, 0, 1, 0);

        // Mgr 3 long packet with valid gaps while mgr 0 waits
        add_pkt(3, 6, 0, 64'h300);
        add_pkt(0, 1, 0, 64'h88);
        run_phase(50, 0, -1, 0);

        // Randomized traffic: gaps, backpressure, occasional MOM-started packets
        for (int p = 0; p < 10; p++) begin
            for (int m = 0; m < NM; m++) begin
                n = $urandom_range(3);
                for (int k = 0; k < n; k++)
                    add_pkt(m, $urandom_range(1, 5), ($urandom_range(9) == 0), {$urandom, $urandom});
            end
            run_phase(25, 30, -1, 0);
        end

        // Leave the pointer at 2 so a pointer that survives reset would favour mgr 3
        add_pkt(1, 1, 0, 64'h11);
        run_phase(0, 0, -1, 0);

        // Reset in the middle of a packet on mgr 1
        mon_en = 1'b0;
        @(posedge clk); #1;
        mgr_valid[1] = 1'b1; mgr_cntl[3:2] = 2'b01; mgr_data[127:64] = 64'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mgr_cntl[3:2] = 2'b00; mgr_data[127:64] = 64'd2;
        @(posedge clk); #1;
        mgr_data[127:64] = 64'd3;
        @(negedge clk);
        chk("pre_rst_busy", 68'(busy), 68'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {ready_o, out_v, out_cntl, out_type, out_data, grant_id, busy}, '0);
        mgr_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        exp_out.delete();
        exp_mgr.delete();
        prev_v = 1'b0;
        mon_en = 1'b1;
        add_pkt(1, 1, 0, 64'hB1);
        add_pkt(3, 1, 0, 64'hB3);
        run_phase(0, 0, -1, 0);

        // A final randomized phase after reset
        for (int m = 0; m < NM; m++)
            add_pkt(m, $urandom_range(1, 4), 0, {$urandom, $urandom});
        run_phase(20, 20, -1, 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
